// File: rtl/bist_misr_analyzer.sv
// Output response analyser for the LFSR-based BIST chain.
// Compacts a programmed number of CUT responses into a MISR. The final
// signature is then compared with a golden value and pass/fail is reported.
//
// Handshake: resp_in is consumed on every rising edge where the FSM is in
// RUN and resp_valid=1. There is no ready signal, because the analyser
// always accepts a response in RUN. In IDLE, CHECK and DONE, responses are
// dropped.
module bist_misr_analyzer #(
  parameter int               WIDTH         = 4,
  parameter logic [WIDTH-1:0] POLY          = 4'b0100,
  parameter logic [WIDTH-1:0] SEED          = 4'b0000,
  parameter int               PATTERN_COUNT = 15,
  parameter logic [WIDTH-1:0] GOLDEN        = 4'b0000,
  parameter int               CNT_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             resp_valid,
  input  logic [WIDTH-1:0] resp_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [WIDTH-1:0] signature,
  output logic [CNT_W-1:0] pat_cnt,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sig_q;
  logic [WIDTH-1:0] misr_next;
  logic [CNT_W-1:0] cnt_q;
  logic             pass_q, fail_q;
  logic             last_resp;

  assign last_resp = (cnt_q == CNT_W'(PATTERN_COUNT - 1));

  // MISR next value: shift toward bit 0, feed sig[0] back through POLY taps, fold in response
  always_comb begin
    misr_next            = '0;
    misr_next[WIDTH-1]   = sig_q[0] ^ resp_in[WIDTH-1];
    for (int i = 0; i < WIDTH - 1; i++) begin
      misr_next[i] = sig_q[i+1] ^ (POLY[i] & sig_q[0]) ^ resp_in[i];
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (resp_valid && last_resp) state_d = S_CHECK;
      S_CHECK: state_d = S_DONE;
      S_DONE:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Signature, pattern counter and verdict registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      sig_q  <= SEED;
      cnt_q  <= '0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            sig_q <= SEED;
            cnt_q <= '0;
          end
        end
        S_RUN: begin
          // The last valid leaves cnt at PATTERN_COUNT; no further increments until restart
          if (resp_valid) begin
            sig_q <= misr_next;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_CHECK: begin
          pass_q <= (sig_q == GOLDEN);
          fail_q <= (sig_q != GOLDEN);
        end
        S_DONE: begin
          if (start) begin
            sig_q  <= SEED;
            cnt_q  <= '0;
            pass_q <= 1'b0;
            fail_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q == S_RUN) || (state_q == S_CHECK);
  assign done      = (state_q == S_DONE);
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign signature = sig_q;
  assign pat_cnt   = cnt_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_bist_misr_analyzer.sv
// Bench for bist_misr_analyzer: two instances share stimulus, one with a
// matching golden value and one with a mismatching golden value.
module tb_bist_misr_analyzer;

  localparam int         W      = 4;
  localparam int         PC     = 2;
  localparam int         CW     = 4;
  localparam logic [3:0] POLY_T = 4'b0100;
  localparam logic [3:0] SEED_T = 4'b0000;
  localparam logic [3:0] GOLD_A = 4'b1100;
  localparam logic [3:0] GOLD_B = 4'b1101;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          resp_valid;
  logic [W-1:0]  resp_in;
  logic          busy_a, done_a, pass_a, fail_a;
  logic          busy_b, done_b, pass_b, fail_b;
  logic [W-1:0]  sig_a, sig_b;
  logic [CW-1:0] cnt_a, cnt_b;
  logic [1:0]    st_a, st_b;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];
  logic         exp_pass_q[$];
  logic [W-1:0] m_sig;
  int           m_cnt;

  bist_misr_analyzer #(.WIDTH(W), .POLY(POLY_T), .SEED(SEED_T), .PATTERN_COUNT(PC),
                       .GOLDEN(GOLD_A), .CNT_W(CW)) dut_a (
    .clk(clk), .rst(rst), .start(start), .resp_valid(resp_valid), .resp_in(resp_in),
    .busy(busy_a), .done(done_a), .pass(pass_a), .fail(fail_a),
    .signature(sig_a), .pat_cnt(cnt_a), .state_dbg(st_a)
  );

  bist_misr_analyzer #(.WIDTH(W), .POLY(POLY_T), .SEED(SEED_T), .PATTERN_COUNT(PC),
                       .GOLDEN(GOLD_B), .CNT_W(CW)) dut_b (
    .clk(clk), .rst(rst), .start(start), .resp_valid(resp_valid), .resp_in(resp_in),
    .busy(busy_b), .done(done_b), .pass(pass_b), .fail(fail_b),
    .signature(sig_b), .pat_cnt(cnt_b), .state_dbg(st_b)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference MISR written from the update equation
  function automatic logic [3:0] misr_model(input logic [3:0] s, input logic [3:0] r);
    logic [3:0] p;
    logic [3:0] n;
    p    = POLY_T;
    n[3] = s[0] ^ r[3];
    for (int i = 0; i < 3; i++) n[i] = s[i+1] ^ (p[i] & s[0]) ^ r[i];
    return n;
  endfunction

  // driver: start a run (optionally with a simultaneous response that must be dropped)
  task automatic start_run(input bit with_valid);
    start      = 1'b1;
    resp_valid = with_valid;
    resp_in    = 4'($urandom_range(0, 15));
    tick();
    start      = 1'b0;
    resp_valid = 1'b0;
    m_sig      = SEED_T;
    m_cnt      = 0;
    chk("start_busy",  8'(busy_a), 8'd1);
    chk("start_sig",   8'(sig_a),  8'(SEED_T));
    chk("start_cnt",   8'(cnt_a),  8'd0);
    chk("start_done",  8'(done_a), 8'd0);
    chk("start_pass",  8'(pass_a), 8'd0);
    chk("start_fail",  8'(fail_b), 8'd0);
  endtask

  // driver: one valid response; optionally pulse start alongside (must be ignored in RUN)
  task automatic send_resp(input logic [3:0] r, input bit last, input bit with_start);
    logic [3:0] e;
    resp_valid = 1'b1;
    resp_in    = r;
    start      = with_start;
    m_sig      = misr_model(m_sig, r);
    m_cnt++;
    exp_q.push_back(m_sig);
    if (last) exp_pass_q.push_back(m_sig == GOLD_A);
    tick();
    resp_valid = 1'b0;
    start      = 1'b0;
    resp_in    = 4'($urandom_range(0, 15));
    if (exp_q.size() == 0) begin
      chk("sig_q_empty", 8'd1, 8'd0);
    end else begin
      e = exp_q.pop_front();
      chk("resp_sig", 8'(sig_a), 8'(e));
    end
    chk("resp_cnt", 8'(cnt_a), 8'(m_cnt));
  endtask

  // driver: resp_valid low for n cycles; everything must hold
  task automatic stall(input int n);
    for (int i = 0; i < n; i++) begin
      resp_in = 4'($urandom_range(0, 15));
      tick();
      chk("stall_sig",  8'(sig_a),  8'(m_sig));
      chk("stall_cnt",  8'(cnt_a),  8'(m_cnt));
      chk("stall_busy", 8'(busy_a), 8'd1);
    end
  endtask

  // after the last response: one CHECK cycle, then verdict on the second edge
  task automatic finish_check();
    logic p;
    chk("chk_done0", 8'(done_a), 8'd0);
    chk("chk_busy",  8'(busy_a), 8'd1);
    chk("chk_pass0", 8'(pass_a), 8'd0);
    resp_valid = 1'b1;
    resp_in    = 4'($urandom_range(0, 15));
    tick();
    resp_valid = 1'b0;
    chk("done_a",    8'(done_a), 8'd1);
    chk("done_busy", 8'(busy_a), 8'd0);
    chk("done_sig",  8'(sig_a),  8'(m_sig));
    chk("done_cnt",  8'(cnt_a),  8'(PC));
    if (exp_pass_q.size() == 0) begin
      chk("pass_q_empty", 8'd1, 8'd0);
    end else begin
      p = exp_pass_q.pop_front();
      chk("pass_a", 8'(pass_a), 8'(p));
      chk("fail_a", 8'(fail_a), 8'(!p));
    end
    chk("done_b", 8'(done_b), 8'd1);
    chk("pass_b", 8'(pass_b), 8'(m_sig == GOLD_B));
    chk("fail_b", 8'(fail_b), 8'(m_sig != GOLD_B));
    // DONE ignores responses and holds everything
    resp_valid = 1'b1;
    resp_in    = 4'($urandom_range(0, 15));
    tick();
    resp_valid = 1'b0;
    chk("hold_sig",  8'(sig_a),  8'(m_sig));
    chk("hold_cnt",  8'(cnt_a),  8'(PC));
    chk("hold_done", 8'(done_a), 8'd1);
    chk("hold_pass", 8'(pass_a), 8'(m_sig == GOLD_A));
  endtask

  task automatic run_two(input logic [3:0] r0, input logic [3:0] r1, input int stall_n,
                         input bit start_in_run);
    start_run(1'b0);
    send_resp(r0, 1'b0, 1'b0);
    stall(stall_n);
    send_resp(r1, 1'b1, start_in_run);
    finish_check();
  endtask

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    resp_valid = 1'b0;
    resp_in    = '0;
    m_sig      = SEED_T;
    m_cnt      = 0;

    // 1: reset with random inputs
    for (int i = 0; i < 3; i++) begin
      start      = 1'($urandom_range(0, 1));
      resp_valid = 1'($urandom_range(0, 1));
      resp_in    = 4'($urandom_range(0, 15));
      tick();
      chk("rst_sig",   8'(sig_a),  8'(SEED_T));
      chk("rst_cnt",   8'(cnt_a),  8'd0);
      chk("rst_flags", 8'({busy_a, done_a, pass_a, fail_a}), 8'd0);
      chk("rst_state", 8'(st_a),   8'd0);
    end
    start      = 1'b0;
    resp_valid = 1'b0;
    rst        = 1'b1;
    tick();

    // 2/3: directed run, signature 0001 then 1100; dut_a passes, dut_b fails
    run_two(4'b0001, 4'b0000, 0, 1'b0);
    chk("s2_sig_abs", 8'(sig_a), 8'h0c);
    chk("s2_pass",    8'(pass_a), 8'd1);
    chk("s3_fail_b",  8'(fail_b), 8'd1);

    // 4: same run with three stall cycles; also restart from DONE
    run_two(4'b0001, 4'b0000, 3, 1'b0);
    chk("s4_sig_abs", 8'(sig_a), 8'h0c);

    // 5: reset at pat_cnt=1
    start_run(1'b0);
    send_resp(4'b1010, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("s5_sig",   8'(sig_a),  8'(SEED_T));
    chk("s5_cnt",   8'(cnt_a),  8'd0);
    chk("s5_flags", 8'({busy_a, done_a, pass_a, fail_a}), 8'd0);
    m_sig = SEED_T;
    tick();
    chk("s5_idle_done", 8'(done_a), 8'd0);

    // start with a response in IDLE: the response is dropped
    start_run(1'b1);
    send_resp(4'b0001, 1'b0, 1'b0);
    send_resp(4'b0000, 1'b1, 1'b0);
    finish_check();

    // 6: start pulsed in RUN alongside the last response is ignored
    run_two(4'b0110, 4'b1001, 1, 1'b1);

    // random runs
    for (int k = 0; k < 8; k++) begin
      run_two(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    chk("exp_q_drained",      8'(exp_q.size()),      8'd0);
    chk("exp_pass_q_drained", 8'(exp_pass_q.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
